// File: rtl/iotdf_batch_filter.sv
// Purpose: packs a byte stream into words, groups words into batches and emits PASS/MAX/MIN/AVG results.
// Latency: PASS results appear 2 edges after a word's last byte; batch results appear at the FLUSH exit edge.
// Backpressure: busy is high for the single FLUSH cycle after each batch, and a byte offered then is dropped.
module iotdf_batch_filter #(
  parameter int WORD_BYTES  = 16,
  parameter int BATCH_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_en,
  input  logic [7:0]                iot_in,
  input  logic [2:0]                fn_sel,
  output logic                      busy,
  output logic                      valid,
  output logic [8*WORD_BYTES-1:0]   iot_out
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int SH_W   = WORD_W - 8;
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WC_W   = $clog2(BATCH_WORDS);
  localparam int ACC_W  = WORD_W + WC_W;

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_BYTES - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BATCH_WORDS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;

  localparam logic [2:0] FN_PASS = 3'd0;
  localparam logic [2:0] FN_MAX  = 3'd1;
  localparam logic [2:0] FN_MIN  = 3'd2;
  localparam logic [2:0] FN_AVG  = 3'd3;

  logic [1:0]        state_q, state_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_v_q, word_v_d;
  logic              word_first_q, word_first_d;
  logic [2:0]        mode_q, mode_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] iot_out_q, iot_out_d;

  logic              accept;
  logic              last_byte;
  logic              last_word;
  logic [WORD_W-1:0] acc_lo;
  logic [ACC_W-1:0]  acc_sum;
  logic [WORD_W-1:0] max_w;
  logic [WORD_W-1:0] min_w;

  assign busy      = (state_q == S_FLUSH);
  assign accept    = in_en && !busy;
  assign last_byte = (bc_q == BC_LAST);
  assign last_word = (wc_q == WC_LAST);

  // MAX/MIN only ever hold a zero-extended word, so the low WORD_W bits are the running value.
  assign acc_lo  = acc_q[WORD_W-1:0];
  assign acc_sum = acc_q + {{WC_W{1'b0}}, word_q};
  assign max_w   = (acc_lo > word_q) ? acc_lo : word_q;
  assign min_w   = (acc_lo < word_q) ? acc_lo : word_q;

  assign valid   = valid_q;
  assign iot_out = iot_out_q;

  // Byte framing: shift bytes in MSB-first, publish a completed word for one cycle, count words.
  always_comb begin
    bc_d         = bc_q;
    wc_d         = wc_q;
    sh_d         = sh_q;
    word_d       = word_q;
    word_v_d     = 1'b0;
    word_first_d = word_first_q;
    mode_d       = mode_q;
    if (accept) begin
      sh_d = SH_W'({sh_q, iot_in});
      bc_d = last_byte ? '0 : bc_q + 1'b1;
      if (state_q == S_IDLE) begin
        mode_d = fn_sel;
      end
      if (last_byte) begin
        word_d       = {sh_q, iot_in};
        word_v_d     = 1'b1;
        word_first_d = (wc_q == '0);
        wc_d         = last_word ? '0 : wc_q + 1'b1;
      end
    end
  end

  // Batch FSM: FLUSH lasts exactly one cycle so the final word can be combined.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_COLLECT;
      S_COLLECT: if (accept && last_byte && last_word) state_d = S_FLUSH;
      S_FLUSH:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Accumulate each word the cycle after it completes; the final word is folded in at FLUSH exit.
  always_comb begin
    acc_d     = acc_q;
    valid_d   = 1'b0;
    iot_out_d = iot_out_q;
    if (state_q == S_FLUSH) begin
      acc_d = '0;
      case (mode_q)
        FN_PASS: begin iot_out_d = word_q; valid_d = 1'b1; end
        FN_MAX:  begin iot_out_d = max_w;  valid_d = 1'b1; end
        FN_MIN:  begin iot_out_d = min_w;  valid_d = 1'b1; end
        FN_AVG:  begin iot_out_d = WORD_W'(acc_sum >> WC_W); valid_d = 1'b1; end
        default: ;
      endcase
    end else if (word_v_q) begin
      case (mode_q)
        FN_PASS: begin iot_out_d = word_q; valid_d = 1'b1; end
        FN_MAX:  acc_d = word_first_q ? {{WC_W{1'b0}}, word_q} : {{WC_W{1'b0}}, max_w};
        FN_MIN:  acc_d = word_first_q ? {{WC_W{1'b0}}, word_q} : {{WC_W{1'b0}}, min_w};
        FN_AVG:  acc_d = word_first_q ? {{WC_W{1'b0}}, word_q} : acc_sum;
        default: ;
      endcase
    end
  end

  // State registers; reset drops any partially collected bytes and words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bc_q         <= '0;
      wc_q         <= '0;
      sh_q         <= '0;
      word_q       <= '0;
      word_v_q     <= 1'b0;
      word_first_q <= 1'b0;
      mode_q       <= FN_PASS;
      acc_q        <= '0;
      valid_q      <= 1'b0;
      iot_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      bc_q         <= bc_d;
      wc_q         <= wc_d;
      sh_q         <= sh_d;
      word_q       <= word_d;
      word_v_q     <= word_v_d;
      word_first_q <= word_first_d;
      mode_q       <= mode_d;
      acc_q        <= acc_d;
      valid_q      <= valid_d;
      iot_out_q    <= iot_out_d;
    end
  end

endmodule

// File: tb/tb_iotdf_batch_filter.sv
// Directed bench for iotdf_batch_filter: MAX/MIN/AVG/PASS batches, fn_sel latching,
// dropped byte during FLUSH, reset mid-batch and a reserved function code.
module tb_iotdf_batch_filter;

  localparam int WB = 16;
  localparam int BW = 8;
  localparam int WW = 8 * WB;

  logic          clk;
  logic          rst;
  logic          in_en;
  logic [7:0]    iot_in;
  logic [2:0]    fn_sel;
  logic          busy;
  logic          valid;
  logic [WW-1:0] iot_out;

  iotdf_batch_filter #(.WORD_BYTES(WB), .BATCH_WORDS(BW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_en   (in_en),
    .iot_in  (iot_in),
    .fn_sel  (fn_sel),
    .busy    (busy),
    .valid   (valid),
    .iot_out (iot_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcnt     = 0;

  logic [WW-1:0] v_dat_q [$];
  int            v_cyc_q [$];
  int            lb_cyc_q [$];
  logic [WW-1:0] bw [BW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: read #1 after an edge it already includes that edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid) begin
      vcnt <= vcnt + 1;
      v_dat_q.push_back(iot_out);
      v_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    for (int i = 0; i < WB; i++) begin
      in_en  = 1'b1;
      iot_in = w[WW-1-8*i -: 8];
      @(posedge clk);
      #1;
    end
    lb_cyc_q.push_back(cyc);
  endtask

  // Send bw[0..7] back to back, optionally switching fn_sel at word chg_word and
  // optionally offering a byte during the FLUSH cycle.
  task automatic run_batch(input string tag, input logic [2:0] fn, input int chg_word,
                           input logic [2:0] fn2, input logic drop,
                           input logic [WW-1:0] exp, input int exp_cnt);
    int v0;
    v0     = vcnt;
    fn_sel = fn;
    for (int k = 0; k < BW; k++) begin
      if (k == chg_word) fn_sel = fn2;
      send_word(bw[k]);
    end
    in_en  = drop;
    iot_in = 8'hAA;
    chk({tag, "_flush_busy"}, busy, 1);
    chk({tag, "_flush_valid"}, valid, 0);
    @(posedge clk);
    #1;
    in_en = 1'b0;
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_valid"}, valid, (exp_cnt > 0) ? 1 : 0);
    chk({tag, "_out"}, iot_out, exp);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_nvalid"}, vcnt - v0, exp_cnt);
  endtask

  task automatic load_small(input int a0, input int a1, input int a2, input int a3,
                            input int a4, input int a5, input int a6, input int a7);
    bw[0] = WW'(a0); bw[1] = WW'(a1); bw[2] = WW'(a2); bw[3] = WW'(a3);
    bw[4] = WW'(a4); bw[5] = WW'(a5); bw[6] = WW'(a6); bw[7] = WW'(a7);
  endtask

  initial begin
    logic [7:0] b;
    int v0;
    rst    = 1'b1;
    in_en  = 1'b0;
    iot_in = 8'h00;
    fn_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_out", iot_out, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // MAX of 3,9,1,7,2,8,5,4 is 9; MIN is 1.
    load_small(3, 9, 1, 7, 2, 8, 5, 4);
    run_batch("max", 3'd1, -1, 3'd0, 1'b0, WW'(9), 1);
    run_batch("min", 3'd2, -1, 3'd0, 1'b0, WW'(1), 1);
    for (int k = 0; k < BW; k++) bw[k] = '1;
    run_batch("min_ones", 3'd2, -1, 3'd0, 1'b0, '1, 1);

    // AVG: 1..8 sums to 36, 36>>3 = 4; eight all-ones words average to all-ones.
    load_small(1, 2, 3, 4, 5, 6, 7, 8);
    run_batch("avg", 3'd3, -1, 3'd0, 1'b0, WW'(4), 1);
    for (int k = 0; k < BW; k++) bw[k] = '1;
    run_batch("avg_ones", 3'd3, -1, 3'd0, 1'b0, '1, 1);

    // PASS: every word comes back, in the cycle after the edge following its last byte.
    for (int k = 0; k < BW; k++) begin
      b     = 8'h10 + 8'(k);
      bw[k] = 128'h000102030405060708090A0B0C0D0E0F ^ {WB{b}};
    end
    v_dat_q.delete();
    v_cyc_q.delete();
    lb_cyc_q.delete();
    run_batch("pass", 3'd0, -1, 3'd0, 1'b0, bw[7], BW);
    chk("pass_count", v_dat_q.size(), BW);
    for (int k = 0; k < BW && k < v_dat_q.size(); k++) begin
      chk($sformatf("pass_dat%0d", k), v_dat_q[k], bw[k]);
      chk($sformatf("pass_cyc%0d", k), v_cyc_q[k], lb_cyc_q[k] + 1);
    end

    // fn_sel switches MAX->MIN at word 3: the batch must still produce MAX.
    // A byte offered during FLUSH is dropped; the following batch resends it.
    load_small(3, 9, 1, 7, 2, 8, 5, 4);
    run_batch("latch", 3'd1, 3, 3'd2, 1'b1, WW'(9), 1);
    for (int k = 0; k < BW; k++) bw[k] = {8'hAA, 112'd0, 8'(k + 1)};
    run_batch("realign", 3'd1, -1, 3'd0, 1'b0, {8'hAA, 112'd0, 8'd8}, 1);

    // Reset after 70 bytes of an AVG batch: nothing is emitted for the partial batch.
    fn_sel = 3'd3;
    load_small(11, 22, 33, 44, 55, 66, 77, 88);
    for (int k = 0; k < 4; k++) send_word(bw[k]);
    for (int i = 0; i < 6; i++) begin
      in_en  = 1'b1;
      iot_in = 8'h5A;
      @(posedge clk);
      #1;
    end
    v0    = vcnt;
    in_en = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_valid", valid, 0);
    chk("rst2_out", iot_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst2_nvalid", vcnt - v0, 0);

    load_small(1, 2, 3, 4, 5, 6, 7, 8);
    run_batch("max_after_rst", 3'd1, -1, 3'd0, 1'b0, WW'(8), 1);

    // Reserved function 5: batch consumed, FLUSH still happens, output holds 8.
    for (int k = 0; k < BW; k++) bw[k] = '1;
    run_batch("reserved", 3'd5, -1, 3'd0, 1'b0, WW'(8), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
